// File: rtl/srm_ctrl_seq.sv
// Multi-cycle control sequencer for the SRM-Starter core: decodes the IR opcode into the
// datapath control word and sequences instruction fetch, data memory access and interrupt entry.
module srm_ctrl_seq #(
  parameter int OPC_HI = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_bus,
  input  logic        ifetch_ack,
  input  logic        mem_ack,
  input  logic        cond_true,
  input  logic        irq,
  output logic [14:0] control_lines,
  output logic        ifetch_req,
  output logic        pc_inc,
  output logic        ks_mode,
  output logic        illegal
);

  typedef enum logic [2:0] {
    RIDLE,
    FETCH,
    EXEC,
    MEM,
    INT_SAVE,
    INT_VEC,
    HALT
  } state_t;

  localparam logic [4:0] OP_NOP = 5'h00;
  localparam logic [4:0] OP_ALR = 5'h01;
  localparam logic [4:0] OP_ALI = 5'h02;
  localparam logic [4:0] OP_LUI = 5'h03;
  localparam logic [4:0] OP_LD  = 5'h04;
  localparam logic [4:0] OP_ST  = 5'h05;
  localparam logic [4:0] OP_JMP = 5'h06;
  localparam logic [4:0] OP_BCC = 5'h07;
  localparam logic [4:0] OP_IJR = 5'h08;
  localparam logic [4:0] OP_SWI = 5'h09;
  localparam logic [4:0] OP_RTI = 5'h0A;
  localparam logic [4:0] OP_SRW = 5'h0B;
  localparam logic [4:0] OP_HLT = 5'h1F;

  localparam logic [2:0] PCIN_JMP   = 3'b000;
  localparam logic [2:0] PCIN_COND  = 3'b001;
  localparam logic [2:0] PCIN_IJR   = 3'b010;
  localparam logic [2:0] PCIN_DB_IN = 3'b011;
  localparam logic [2:0] PCIN_IRD   = 3'b100;

  localparam logic [1:0] REGIN_UIMM = 2'b01;
  localparam logic [1:0] REGIN_MEM  = 2'b10;

  localparam logic [1:0] MADDR_LOAD  = 2'b01;
  localparam logic [1:0] MADDR_S_INT = 2'b10;
  localparam logic [1:0] MADDR_H_INT = 2'b11;

  state_t state_q, state_d;
  logic   fetch_entry_q, fetch_entry_d;
  logic   ks_mode_q, ks_mode_d;
  logic   mem_ld_q, mem_ld_d;
  logic   int_hw_q, int_hw_d;

  logic [4:0] opcode;
  logic       inst_unused;

  logic       c_we, alu_bsel, pc_jmp, sr_we, mem_we, ks, ir_tsf, mem_req;
  logic [2:0] pc_in;
  logic [1:0] reg_in, mem_addr;

  assign opcode      = inst_bus[OPC_HI -: 5];
  assign inst_unused = ^(inst_bus & ~(32'h1F << (OPC_HI - 4)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RIDLE;
      fetch_entry_q <= 1'b0;
      ks_mode_q     <= 1'b1;
      mem_ld_q      <= 1'b0;
      int_hw_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_entry_q <= fetch_entry_d;
      ks_mode_q     <= ks_mode_d;
      mem_ld_q      <= mem_ld_d;
      int_hw_q      <= int_hw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ks_mode_d  = ks_mode_q;
    mem_ld_d   = mem_ld_q;
    int_hw_d   = int_hw_q;
    c_we       = 1'b0;
    alu_bsel   = 1'b0;
    pc_jmp     = 1'b0;
    sr_we      = 1'b0;
    mem_we     = 1'b0;
    ks         = 1'b0;
    pc_in      = PCIN_JMP;
    reg_in     = 2'b00;
    mem_addr   = 2'b00;
    ir_tsf     = 1'b0;
    mem_req    = 1'b0;
    ifetch_req = 1'b0;
    pc_inc     = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      RIDLE: state_d = FETCH;

      FETCH: begin
        ifetch_req = 1'b1;
        // Interrupts are only considered on the first FETCH cycle, i.e. at an instruction boundary.
        if (fetch_entry_q && irq && !ks_mode_q) begin
          state_d  = INT_SAVE;
          int_hw_d = 1'b1;
        end else if (ifetch_ack) begin
          state_d = EXEC;
        end
      end

      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_NOP: pc_inc = 1'b1;
          OP_ALR: begin
            c_we   = 1'b1;
            sr_we  = 1'b1;
            pc_inc = 1'b1;
          end
          OP_ALI: begin
            c_we     = 1'b1;
            sr_we    = 1'b1;
            alu_bsel = 1'b1;
            pc_inc   = 1'b1;
          end
          OP_LUI: begin
            c_we   = 1'b1;
            reg_in = REGIN_UIMM;
            pc_inc = 1'b1;
          end
          OP_LD: begin
            state_d  = MEM;
            mem_ld_d = 1'b1;
          end
          OP_ST: begin
            state_d  = MEM;
            mem_ld_d = 1'b0;
          end
          OP_JMP: begin
            pc_jmp = 1'b1;
            pc_in  = PCIN_JMP;
          end
          OP_BCC: begin
            pc_in  = PCIN_COND;
            pc_jmp = cond_true;
            pc_inc = !cond_true;
          end
          OP_IJR: begin
            pc_jmp = 1'b1;
            pc_in  = PCIN_IJR;
          end
          OP_SWI: begin
            state_d  = INT_SAVE;
            int_hw_d = 1'b0;
          end
          OP_RTI: begin
            pc_jmp    = 1'b1;
            pc_in     = PCIN_IRD;
            ks_mode_d = 1'b0;
          end
          OP_SRW: begin
            sr_we  = 1'b1;
            pc_inc = 1'b1;
          end
          OP_HLT: state_d = HALT;
          default: begin
            illegal = 1'b1;
            pc_inc  = 1'b1;
          end
        endcase
      end

      MEM: begin
        // Address/steering are held for the whole access; only the ack-cycle qualifiers vary.
        mem_req = 1'b1;
        if (mem_ld_q) begin
          mem_addr = MADDR_LOAD;
          reg_in   = REGIN_MEM;
          c_we     = mem_ack;
        end else begin
          mem_we = 1'b1;
        end
        if (mem_ack) begin
          pc_inc  = 1'b1;
          state_d = FETCH;
        end
      end

      INT_SAVE: begin
        ir_tsf    = 1'b1;
        ks        = 1'b1;
        ks_mode_d = 1'b1;
        state_d   = INT_VEC;
      end

      INT_VEC: begin
        mem_req  = 1'b1;
        mem_addr = int_hw_q ? MADDR_H_INT : MADDR_S_INT;
        pc_in    = PCIN_DB_IN;
        if (mem_ack) begin
          pc_jmp  = 1'b1;
          state_d = FETCH;
        end
      end

      HALT: begin
        if (irq && !ks_mode_q) begin
          state_d  = INT_SAVE;
          int_hw_d = 1'b1;
        end
      end

      default: state_d = RIDLE;
    endcase

    fetch_entry_d = (state_d == FETCH) && (state_q != FETCH);
  end

  assign control_lines = {mem_req, ir_tsf, mem_addr, reg_in, pc_in, ks, mem_we, sr_we,
                          pc_jmp, alu_bsel, c_we};
  assign ks_mode       = ks_mode_q;

endmodule

// File: tb/tb_srm_ctrl_seq.sv
// Randomized bench for srm_ctrl_seq: a transaction-level model pushes one expected output
// tuple per cycle into a queue and a negedge monitor pops and compares it.
module tb_srm_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_bus;
  logic        ifetch_ack, mem_ack, cond_true, irq;
  logic [14:0] control_lines;
  logic        ifetch_req, pc_inc, ks_mode, illegal;

  srm_ctrl_seq #(.OPC_HI(31)) dut (
    .clk(clk), .rst(rst), .inst_bus(inst_bus), .ifetch_ack(ifetch_ack), .mem_ack(mem_ack),
    .cond_true(cond_true), .irq(irq), .control_lines(control_lines), .ifetch_req(ifetch_req),
    .pc_inc(pc_inc), .ks_mode(ks_mode), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [14:0] cl;
    logic        req;
    logic        inc;
    logic        ks;
    logic        ill;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    chk_en = 1'b0;
  bit    ks_m   = 1'b1;
  int    irq_mode  = 0;
  int    irq_delay = 0;

  // Monitor: every cycle the DUT presents a full output tuple.
  always @(negedge clk) begin
    exp_t  e, a;
    string t;
    if (chk_en) begin
      a = {control_lines, ifetch_req, pc_inc, ks_mode, illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL no_expectation: t=%0t actual cl=%h", $time, control_lines);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL %s: t=%0t actual cl=%h req=%b inc=%b ks=%b ill=%b, expected cl=%h req=%b inc=%b ks=%b ill=%b",
                   t, $time, a.cl, a.req, a.inc, a.ks, a.ill, e.cl, e.req, e.inc, e.ks, e.ill);
        end
      end
    end
  end

  function automatic logic [14:0] mk(input logic c_we, bsel, jmp, sr, mwe, ks,
                                     input logic [2:0] pcin, input logic [1:0] regin, maddr,
                                     input logic irt, mreq);
    return {mreq, irt, maddr, regin, pcin, ks, mwe, sr, jmp, bsel, c_we};
  endfunction

  function logic pick_irq();
    case (irq_mode)
      0: return 1'b0;
      1: return 1'b1;
      3: begin
        if (irq_delay > 0) begin
          irq_delay--;
          return 1'b0;
        end
        return 1'b1;
      end
      default: return ($urandom_range(0, 4) == 0);
    endcase
  endfunction

  // kind: 0 plain, 1 load, 2 store, 3 software interrupt, 4 halt
  function automatic void exec_model(input logic [4:0] op, input logic c, output logic [14:0] cl,
                                     output logic inc, ill, output int kind);
    cl = '0; inc = 1'b0; ill = 1'b0; kind = 0;
    case (op)
      5'h00: inc = 1'b1;
      5'h01: begin cl = mk(1, 0, 0, 1, 0, 0, 3'd0, 2'd0, 2'd0, 0, 0); inc = 1'b1; end
      5'h02: begin cl = mk(1, 1, 0, 1, 0, 0, 3'd0, 2'd0, 2'd0, 0, 0); inc = 1'b1; end
      5'h03: begin cl = mk(1, 0, 0, 0, 0, 0, 3'd0, 2'd1, 2'd0, 0, 0); inc = 1'b1; end
      5'h04: kind = 1;
      5'h05: kind = 2;
      5'h06: cl = mk(0, 0, 1, 0, 0, 0, 3'd0, 2'd0, 2'd0, 0, 0);
      5'h07: begin cl = mk(0, 0, c, 0, 0, 0, 3'd1, 2'd0, 2'd0, 0, 0); inc = !c; end
      5'h08: cl = mk(0, 0, 1, 0, 0, 0, 3'd2, 2'd0, 2'd0, 0, 0);
      5'h09: kind = 3;
      5'h0A: cl = mk(0, 0, 1, 0, 0, 0, 3'd4, 2'd0, 2'd0, 0, 0);
      5'h0B: begin cl = mk(0, 0, 0, 1, 0, 0, 3'd0, 2'd0, 2'd0, 0, 0); inc = 1'b1; end
      5'h1F: kind = 4;
      default: begin ill = 1'b1; inc = 1'b1; end
    endcase
  endfunction

  task automatic step(input logic [14:0] cl, input logic req, inc, ill, input string tag);
    exp_q.push_back({cl, req, inc, ks_m, ill});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    ifetch_ack = 1'b0;
    mem_ack    = 1'b0;
    cond_true  = 1'($urandom_range(0, 1));
    irq        = pick_irq();
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    ks_m = 1'b1;
    step('0, 0, 0, 0, "reset");
    rst = 1'b0;
    step('0, 0, 0, 0, "ridle");
  endtask

  task automatic do_int(input bit hw, input int vw);
    mem_ack = 1'($urandom_range(0, 1));
    step(mk(0, 0, 0, 0, 0, 1, 3'd0, 2'd0, 2'd0, 1, 0), 0, 0, 0, "int_save");
    ks_m = 1'b1;
    for (int i = 0; i <= vw; i++) begin
      mem_ack    = (i == vw);
      ifetch_ack = 1'($urandom_range(0, 1));
      step(mk(0, 0, (i == vw), 0, 0, 0, 3'd3, 2'd0, hw ? 2'd3 : 2'd2, 0, 1), 0, 0, 0,
           hw ? "int_vec_hw" : "int_vec_sw");
    end
  endtask

  task automatic run_inst(input logic [4:0] op, input logic cond, input int fw, mw, vw, abort_at);
    logic [14:0] cl;
    logic        inc, ill;
    int          kind;
    irq = pick_irq();
    for (int i = 0; i <= fw; i++) begin
      if (i == 0 && irq && !ks_m) begin
        ifetch_ack = 1'($urandom_range(0, 1));
        step('0, 1, 0, 0, "fetch_irq");
        do_int(1'b1, vw);
        return;
      end
      ifetch_ack = (i == fw);
      mem_ack    = 1'($urandom_range(0, 1));
      step('0, 1, 0, 0, "fetch");
    end
    inst_bus   = {op, 27'($urandom)};
    cond_true  = cond;
    mem_ack    = 1'($urandom_range(0, 1));
    ifetch_ack = 1'($urandom_range(0, 1));
    exec_model(op, cond, cl, inc, ill, kind);
    step(cl, 0, inc, ill, "exec");
    if (op == 5'h0A) ks_m = 1'b0;
    if (kind == 1 || kind == 2) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == abort_at) begin
          do_reset();
          return;
        end
        mem_ack    = (i == mw);
        ifetch_ack = 1'($urandom_range(0, 1));
        if (kind == 1)
          step(mk((i == mw), 0, 0, 0, 0, 0, 3'd0, 2'd2, 2'd1, 0, 1), 0, (i == mw), 0, "ld_mem");
        else
          step(mk(0, 0, 0, 0, 1, 0, 3'd0, 2'd0, 2'd0, 0, 1), 0, (i == mw), 0, "st_mem");
      end
    end else if (kind == 3) begin
      do_int(1'b0, vw);
    end else if (kind == 4) begin
      for (int k = 0; k < 12; k++) begin
        bit take;
        take       = irq && !ks_m;
        mem_ack    = 1'($urandom_range(0, 1));
        ifetch_ack = 1'($urandom_range(0, 1));
        step('0, 0, 0, 0, "halt");
        if (take) begin
          do_int(1'b1, vw);
          return;
        end
      end
      do_reset();
    end
  endtask

  initial begin
    logic [4:0] op;
    rst = 1'b1; inst_bus = '0; ifetch_ack = 1'b0; mem_ack = 1'b0; cond_true = 1'b0; irq = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset();

    // Directed scenarios: ALU with fetch waits, LD with memory waits, both BCC outcomes.
    run_inst(5'h01, 0, 2, 0, 0, -1);
    run_inst(5'h04, 0, 0, 3, 0, -1);
    run_inst(5'h07, 0, 1, 0, 0, -1);
    run_inst(5'h07, 1, 0, 0, 0, -1);
    run_inst(5'h0A, 0, 0, 0, 0, -1);
    irq_mode = 1;
    run_inst(5'h00, 0, 0, 0, 2, -1);
    irq_mode = 0;
    run_inst(5'h1E, 0, 0, 0, 0, -1);
    run_inst(5'h09, 0, 1, 0, 1, -1);
    run_inst(5'h0A, 0, 0, 0, 0, -1);
    irq_mode  = 3;
    irq_delay = 4;
    run_inst(5'h1F, 0, 0, 0, 0, -1);
    irq_mode = 0;
    run_inst(5'h05, 0, 0, 3, 0, 1);
    run_inst(5'h02, 0, 0, 0, 0, -1);
    run_inst(5'h03, 0, 0, 0, 0, -1);

    irq_mode = 2;
    repeat (300) begin
      if ($urandom_range(0, 9) < 7) begin
        op = 5'($urandom_range(0, 12));
        if (op == 5'd12) op = 5'h1F;
      end else begin
        op = 5'($urandom_range(0, 31));
      end
      run_inst(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), ($urandom_range(0, 14) == 0) ? $urandom_range(0, 3) : -1);
    end

    chk_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/srm_ctrl_seq.md
# srm_ctrl_seq

Multi-cycle control sequencer for the SRM-Starter core. It decodes the opcode field of the instruction register and drives the 15-bit `control_lines` word that steers the datapath interconnect. It also runs the instruction-fetch and data-memory handshakes and the software/hardware interrupt entry sequence. It sits between the fetch/memory bus interfaces and the datapath, and is the only source of `control_lines`.

## Interface
- `OPC_HI`, 31: MSB of the opcode field; opcode = `inst_bus[OPC_HI:OPC_HI-4]`.
- `clk` in 1: core clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_bus` in 32: current instruction register contents; valid from the cycle after `ifetch_ack`.
- `ifetch_ack` in 1: instruction bus has delivered the word at PC (IR loads on this edge).
- `mem_ack` in 1: data bus has completed the access requested by `control_lines[14]`.
- `cond_true` in 1: branch condition result from the status register for the current instruction.
- `irq` in 1: level hardware interrupt request.
- `control_lines` out 15: datapath control word. Bit map:
  - 0: C_WE
  - 1: ALU_BSEL
  - 2: PC_JMP
  - 3: SR_WE
  - 4: MEM_WE
  - 5: KS
  - 8:6: PC_IN (000 JMP, 001 COND, 010 IJR, 011 DB_IN, 100 IRD)
  - 10:9: REG_IN (00 ALU, 01 UPPER_IMM, 10 MEM)
  - 12:11: MEM_ADDR (00 store, 01 load, 10 S_INT, 11 H_INT)
  - 13: IR_TSF
  - 14: MEM_REQ
- `ifetch_req` out 1: request the instruction at PC.
- `pc_inc` out 1: advance PC by 4. Pulses in the final cycle of every instruction that does not jump.
- `ks_mode` out 1: kernel mode flag. Set on interrupt entry, cleared by RTI.
- `illegal` out 1: one-cycle pulse when an undefined opcode is executed.

## Operation
- States: `RIDLE`, `FETCH`, `EXEC`, `MEM`, `INT_SAVE`, `INT_VEC`, `HALT`.
- Reset: state `RIDLE`; `ks_mode`=1. All outputs are 0 while `rst`=1 and in `RIDLE`. `RIDLE` always moves to `FETCH` on the next edge.
- `FETCH`:
  - The state is sampled on the first cycle in `FETCH`.
  - If `irq`=1 and `ks_mode`=0, go to `INT_SAVE` with H_INT.
  - Otherwise hold `ifetch_req`=1 until `ifetch_ack`, then go to `EXEC`.
- `EXEC` decodes the opcode. Each instruction lasts one cycle and returns to `FETCH` unless noted:
  - 0x00 NOP: only `pc_inc`.
  - 0x01 ALU reg-reg: C_WE, SR_WE, REG_IN=00, BSEL=0, `pc_inc`.
  - 0x02 ALU reg-imm: as 0x01 with BSEL=1.
  - 0x03 LUI: C_WE, REG_IN=01, `pc_inc`.
  - 0x04 LD: go to `MEM` with MEM_ADDR=01, REG_IN=10.
  - 0x05 ST: go to `MEM` with MEM_ADDR=00, MEM_WE=1.
  - 0x06 JMP: PC_JMP, PC_IN=000.
  - 0x07 BCC: PC_IN=001. PC_JMP=`cond_true`; `pc_inc`=!`cond_true`.
  - 0x08 IJR: PC_JMP, PC_IN=010.
  - 0x09 SWI: go to `INT_SAVE` with S_INT.
  - 0x0A RTI: PC_JMP, PC_IN=100, clear `ks_mode`.
  - 0x0B SRW: SR_WE, `pc_inc`.
  - 0x1F HLT: go to `HALT`, no `pc_inc`.
  - Any other opcode: `illegal` pulse plus NOP behaviour.
- `MEM`:
  - MEM_REQ=1 and the selected MEM_ADDR/REG_IN/MEM_WE are held constant until `mem_ack`.
  - For LD, C_WE is asserted only in the `mem_ack` cycle.
  - `pc_inc` is asserted in the `mem_ack` cycle, then go to `FETCH`.
- `INT_SAVE` (one cycle): IR_TSF=1 (return PC saved), KS=1, set `ks_mode`. Go to `INT_VEC`.
- `INT_VEC`:
  - MEM_REQ=1, MEM_ADDR=10 (S_INT, address 0) or 11 (H_INT, address 4), PC_IN=011.
  - PC_JMP=1 only in the `mem_ack` cycle, then go to `FETCH`.
- `HALT`: all outputs 0. Leave to `INT_SAVE` (H_INT) when `irq`=1 and `ks_mode`=0; otherwise stay until reset.

## Timing
- `control_lines`, `ifetch_req` and `pc_inc` are Moore/decode combinational from the registered state and `inst_bus`. No output depends on `ifetch_ack` except the transition.
- Single-cycle instruction: 2 cycles minimum (`FETCH` with ack on the first cycle, then `EXEC`).
- LD/ST: 3 cycles plus memory wait states.
- Interrupt entry: `INT_SAVE` (1 cycle) + `INT_VEC` (≥1 cycle); the first vector fetch follows.
- `irq` is sampled only on the entry cycle of `FETCH` or in `HALT`. An `irq` that rises mid-instruction is taken at the next boundary if still high. SWI takes priority over a simultaneous `irq`; the `irq` is masked because `ks_mode` is then 1.
- `mem_ack` or `ifetch_ack` arriving in any state not waiting for it is ignored.
- `rst` asserted mid-`MEM`/`INT_VEC` forces all outputs to 0 immediately. The bus must tolerate MEM_REQ dropping without ack.

## Test plan
- Reset release → `RIDLE` for 1 cycle (all outputs 0, `ks_mode`=1), then `ifetch_req`=1.
- Fetch 0x01 with `ifetch_ack` after 2 wait cycles → `EXEC` drives `control_lines`=0x009 with `pc_inc`=1; total 4 cycles.
- LD with `mem_ack` after 3 cycles → `control_lines`=0x4C00 held for 3 cycles, then 0x4C01 with `pc_inc` in the ack cycle.
- BCC with `cond_true`=0 → 0x040, `pc_inc`=1. With `cond_true`=1 → 0x044, `pc_inc`=0.
- RTI clears `ks_mode`; `irq`=1 held → at the next `FETCH`: `INT_SAVE` 0x2020, then `INT_VEC` 0x58C0 → 0x58C4 on ack; `ks_mode`=1.
- Opcode 0x1E → `illegal` pulse, `pc_inc`. HLT then `irq` with `ks_mode`=0 → H_INT sequence. `rst` during `MEM` → all outputs 0 asynchronously.
